// File: rtl/axilite_regbank_pkg.sv
// Shared types and elaboration helpers for the parametrised register bank.
// Covers FSM state encoding, byte-address to word-index decode and access-mask sanity checking.
package regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WACK,
    RACK
  } state_t;

  typedef logic [63:0] widx_t;

  localparam int unsigned MASK_MAX_W = 8192;
  typedef logic [MASK_MAX_W-1:0] mask_t;

  function automatic widx_t word_idx(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

  // A bit claimed by an earlier mask and again by a later one is an overlap.
  function automatic logic masks_overlap(input mask_t rw, input mask_t wo, input mask_t w1c,
                                         input mask_t rc, input mask_t pulse);
    mask_t seen;
    mask_t ovl;
    seen = rw;
    ovl  = '0;
    ovl  = ovl | (seen & wo);
    seen = seen | wo;
    ovl  = ovl | (seen & w1c);
    seen = seen | w1c;
    ovl  = ovl | (seen & rc);
    seen = seen | rc;
    ovl  = ovl | (seen & pulse);
    return |ovl;
  endfunction

endpackage

// File: rtl/axilite_regbank_word.sv
// One register word: RW/WO storage, W1C/RC sticky capture, write pulses and clear strobes.
// Masks are per-word slices; bits in no mask are read-only views of hw_in.
module regbank_word #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] RW_MASK    = '0,
  parameter logic [DATA_W-1:0] WO_MASK    = '0,
  parameter logic [DATA_W-1:0] W1C_MASK   = '0,
  parameter logic [DATA_W-1:0] RC_MASK    = '0,
  parameter logic [DATA_W-1:0] PULSE_MASK = '0,
  parameter logic [DATA_W-1:0] RST_VAL    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_be,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] hw_in,
  output logic [DATA_W-1:0] hw_out,
  output logic [DATA_W-1:0] hw_pulse,
  output logic [DATA_W-1:0] hw_clr,
  output logic [DATA_W-1:0] sticky,
  output logic [DATA_W-1:0] rd_val
);

  localparam logic [DATA_W-1:0] STORE_M  = RW_MASK | WO_MASK;
  localparam logic [DATA_W-1:0] STICKY_M = W1C_MASK | RC_MASK;
  localparam logic [DATA_W-1:0] RO_M     = ~(RW_MASK | WO_MASK | W1C_MASK | RC_MASK | PULSE_MASK);

  logic [DATA_W-1:0] store_q, store_d;
  logic [DATA_W-1:0] sticky_q, sticky_d;
  logic [DATA_W-1:0] pulse_q, pulse_d;
  logic [DATA_W-1:0] clr_q, clr_d;
  logic [DATA_W-1:0] clr_req;

  always_comb begin
    store_d = store_q;
    pulse_d = '0;
    clr_req = '0;
    if (wr_en) begin
      store_d = (store_q & ~(wr_be & STORE_M)) | (wr_data & wr_be & STORE_M);
      clr_req = wr_data & wr_be & W1C_MASK;
      pulse_d = wr_data & wr_be & PULSE_MASK;
    end
    if (rd_en) begin
      clr_req = clr_req | RC_MASK;
    end
    // hw_in is OR-ed in after the clear, so a same-cycle set wins.
    sticky_d = ((sticky_q & ~clr_req) | hw_in) & STICKY_M;
    clr_d    = sticky_q & clr_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q  <= RST_VAL & STORE_M;
      sticky_q <= '0;
      pulse_q  <= '0;
      clr_q    <= '0;
    end else begin
      store_q  <= store_d;
      sticky_q <= sticky_d;
      pulse_q  <= pulse_d;
      clr_q    <= clr_d;
    end
  end

  assign hw_out   = store_q;
  assign hw_pulse = pulse_q;
  assign hw_clr   = clr_q;
  assign sticky   = sticky_q;
  assign rd_val   = (store_q & RW_MASK) | sticky_q | (hw_in & RO_M);

endmodule

// File: rtl/axilite_regbank.sv
// Parametrised register bank behind the axilite_slave memory-request interface.
// Holds the access FSM, address decode, read mux and masked interrupt reduction.
module axilite_regbank
  import regbank_pkg::*;
#(
  parameter int unsigned                ADDR_W     = 32,
  parameter int unsigned                DATA_W     = 32,
  parameter int unsigned                N_REGS     = 4,
  parameter logic [N_REGS*DATA_W-1:0]   RW_MASK    = '0,
  parameter logic [N_REGS*DATA_W-1:0]   WO_MASK    = '0,
  parameter logic [N_REGS*DATA_W-1:0]   W1C_MASK   = '0,
  parameter logic [N_REGS*DATA_W-1:0]   RC_MASK    = '0,
  parameter logic [N_REGS*DATA_W-1:0]   PULSE_MASK = '0,
  parameter logic [N_REGS*DATA_W-1:0]   RST_VAL    = '0,
  parameter logic [N_REGS*DATA_W-1:0]   IRQ_MASK   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_w_req,
  input  logic [ADDR_W-1:0]          mem_w_addr,
  input  logic [DATA_W-1:0]          mem_w_data,
  input  logic [DATA_W/8-1:0]        mem_w_strb,
  output logic                       mem_w_ack,
  input  logic                       mem_r_req,
  input  logic [ADDR_W-1:0]          mem_r_addr,
  output logic [DATA_W-1:0]          mem_r_data,
  output logic                       mem_r_ack,
  output logic [N_REGS*DATA_W-1:0]   hw_out,
  input  logic [N_REGS*DATA_W-1:0]   hw_in,
  output logic [N_REGS*DATA_W-1:0]   hw_pulse,
  output logic [N_REGS*DATA_W-1:0]   hw_clr,
  output logic                       decode_err,
  output logic                       irq
);

  localparam int unsigned TOT_W  = N_REGS * DATA_W;
  localparam int unsigned STRB_W = DATA_W / 8;

  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("axilite_regbank: DATA_W must be a multiple of 8");
  end
  if (TOT_W > MASK_MAX_W) begin : g_bad_mask_w
    $error("axilite_regbank: N_REGS*DATA_W exceeds the mask checker width");
  end
  if (masks_overlap(mask_t'(RW_MASK), mask_t'(WO_MASK), mask_t'(W1C_MASK),
                    mask_t'(RC_MASK), mask_t'(PULSE_MASK))) begin : g_mask_overlap
    $error("axilite_regbank: access masks are not mutually exclusive");
  end

  state_t            state_q, state_d;
  logic              w_ack_q, w_ack_d;
  logic              r_ack_q, r_ack_d;
  logic              derr_q, derr_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  widx_t             w_idx, r_idx;
  logic              w_hit, r_hit;
  logic              wr_go, rd_go;
  logic [DATA_W-1:0] wr_be;
  logic [DATA_W-1:0] rd_mux;
  logic [N_REGS-1:0] wr_sel, rd_sel;
  logic [DATA_W-1:0] rd_val [N_REGS];
  logic [TOT_W-1:0]  sticky;

  always_comb begin
    w_idx = word_idx(64'(mem_w_addr));
    r_idx = word_idx(64'(mem_r_addr));
    w_hit = w_idx < widx_t'(N_REGS);
    r_hit = r_idx < widx_t'(N_REGS);
    for (int unsigned b = 0; b < STRB_W; b++) begin
      wr_be[b*8 +: 8] = {8{mem_w_strb[b]}};
    end
  end

  always_comb begin
    state_d = state_q;
    w_ack_d = 1'b0;
    r_ack_d = 1'b0;
    derr_d  = 1'b0;
    rdata_d = rdata_q;
    wr_go   = 1'b0;
    rd_go   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_w_req) begin
          state_d = WACK;
          w_ack_d = 1'b1;
          derr_d  = !w_hit;
          wr_go   = 1'b1;
        end else if (mem_r_req) begin
          state_d = RACK;
          r_ack_d = 1'b1;
          derr_d  = !r_hit;
          rd_go   = 1'b1;
          rdata_d = rd_mux;
        end
      end
      WACK:    state_d = IDLE;
      RACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range indices match no word, so they select nothing and read as zero.
  always_comb begin
    rd_mux = '0;
    wr_sel = '0;
    rd_sel = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (r_idx == widx_t'(i)) begin
        rd_mux = rd_val[i];
      end
      wr_sel[i] = wr_go && (w_idx == widx_t'(i));
      rd_sel[i] = rd_go && (r_idx == widx_t'(i));
    end
  end

  assign irq_d = |(sticky & IRQ_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_ack_q <= 1'b0;
      r_ack_q <= 1'b0;
      derr_q  <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      w_ack_q <= w_ack_d;
      r_ack_q <= r_ack_d;
      derr_q  <= derr_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_word
    regbank_word #(
      .DATA_W     (DATA_W),
      .RW_MASK    (RW_MASK[i*DATA_W +: DATA_W]),
      .WO_MASK    (WO_MASK[i*DATA_W +: DATA_W]),
      .W1C_MASK   (W1C_MASK[i*DATA_W +: DATA_W]),
      .RC_MASK    (RC_MASK[i*DATA_W +: DATA_W]),
      .PULSE_MASK (PULSE_MASK[i*DATA_W +: DATA_W]),
      .RST_VAL    (RST_VAL[i*DATA_W +: DATA_W])
    ) u_word (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_sel[i]),
      .wr_data  (mem_w_data),
      .wr_be    (wr_be),
      .rd_en    (rd_sel[i]),
      .hw_in    (hw_in[i*DATA_W +: DATA_W]),
      .hw_out   (hw_out[i*DATA_W +: DATA_W]),
      .hw_pulse (hw_pulse[i*DATA_W +: DATA_W]),
      .hw_clr   (hw_clr[i*DATA_W +: DATA_W]),
      .sticky   (sticky[i*DATA_W +: DATA_W]),
      .rd_val   (rd_val[i])
    );
  end

  assign mem_w_ack  = w_ack_q;
  assign mem_r_ack  = r_ack_q;
  assign mem_r_data = rdata_q;
  assign decode_err = derr_q;
  assign irq        = irq_q;

endmodule

// File: doc/axilite_regbank.md
# axilite_regbank

Parametrised register bank replacing per-design generated register/adapter pairs. Sits between `axilite_slave`'s memory-request interface and user logic, and provides `N_REGS` words whose bits each take one access type: RW, WO, RO, W1C, RC or PULSE. Per-bit access masks are parameters. Adds in-bank sticky capture for W1C/RC bits, byte strobes, decode-error flagging and a masked, registered interrupt output.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width of `mem_*_addr`.
- `DATA_W`, 32: register width; must be a multiple of 8.
- `N_REGS`, 4: number of words, at byte offsets 0, 4, 8, ….
- `RW_MASK`, 0: `[N_REGS*DATA_W]`; bits that are read/write.
- `WO_MASK`, 0: write-only bits; they drive `hw_out` and read back as 0.
- `W1C_MASK`, 0: sticky bits, set by `hw_in`, cleared by writing 1.
- `RC_MASK`, 0: sticky bits, set by `hw_in`, cleared by a read.
- `PULSE_MASK`, 0: writing 1 produces a 1-cycle `hw_pulse`.
- `RST_VAL`, 0: reset value of RW/WO bits.
- `IRQ_MASK`, 0: sticky bits that feed `irq`.
- Bits in no mask are RO and read `hw_in`. The masks must be mutually exclusive; an elaboration-time assertion checks this.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `mem_w_req`, in, 1: write request, held until ack.
- `mem_w_addr`, in, `ADDR_W`.
- `mem_w_data`, in, `DATA_W`.
- `mem_w_strb`, in, `DATA_W/8`: byte enables.
- `mem_w_ack`, out, 1: 1-cycle write done.
- `mem_r_req`, in, 1: read request, held until ack.
- `mem_r_addr`, in, `ADDR_W`.
- `mem_r_data`, out, `DATA_W`: valid with `mem_r_ack`, held until the next read.
- `mem_r_ack`, out, 1: 1-cycle read done.
- `hw_out`, out, `N_REGS*DATA_W`: RW/WO bit values; 0 elsewhere.
- `hw_in`, in, `N_REGS*DATA_W`: RO values and sticky set inputs (level).
- `hw_pulse`, out, `N_REGS*DATA_W`: PULSE strobes.
- `hw_clr`, out, `N_REGS*DATA_W`: 1-cycle strobe for each sticky bit cleared by software.
- `decode_err`, out, 1: 1-cycle flag on an out-of-range access.
- `irq`, out, 1: registered OR of sticky bits masked by `IRQ_MASK`.

## Operation
- FSM states:
  - IDLE:
    - If `mem_w_req`, go to WACK. Write has priority over read.
    - Else if `mem_r_req`, go to RACK.
  - WACK: `mem_w_ack`=1 for this cycle, then IDLE.
  - RACK: `mem_r_ack`=1 for this cycle, then IDLE.
  - Requests are not re-sampled in the ack cycle, so the minimum spacing between accesses is 2 cycles.
- Decode:
  - Word index = `addr[ADDR_W-1:2]`.
  - An index ≥ `N_REGS` is out of range. The access is still acked: a write has no effect and a read returns 0. `decode_err` pulses with the ack.
- Writes are applied on the IDLE→WACK edge. Only bytes with `strb`=1 are affected.
  - RW/WO bits take the write data.
  - W1C bits are cleared where the data bit is 1.
  - PULSE bits set `hw_pulse` for exactly that one cycle (the WACK cycle).
- Reads: `mem_r_data` is captured on the IDLE→RACK edge.
  - RW and sticky bits read their stored value.
  - RO bits read `hw_in`.
  - WO and PULSE bits read 0.
  - All RC bits of the addressed word are cleared on the same edge.
- Sticky bits: `sticky <= (sticky & ~clr) | hw_in`, evaluated every cycle.
  - If a set and a clear occur in the same cycle, the set wins. The bit stays 1, but `hw_clr` still pulses.
- `hw_clr` is asserted in the WACK/RACK cycle for bits that were 1 and were targeted for clear.
- `irq` = |(sticky & `IRQ_MASK`), registered, so it lags the sticky state by 1 cycle.

## Timing
- Write: `mem_w_ack` and `hw_pulse` appear 1 cycle after `mem_w_req` is sampled high. `hw_out` updates in the same cycle.
- Read: `mem_r_ack` and `mem_r_data` appear 1 cycle after the request. `hw_in` is sampled on the request edge.
- Reset values:
  - FSM = IDLE.
  - All acks, `hw_pulse`, `hw_clr`, `decode_err` and `irq` = 0.
  - `mem_r_data` = 0.
  - Sticky bits = 0.
  - RW/WO bits = `RST_VAL`.
- Reset asserted mid-access: the pending ack is dropped. The requester must re-issue after reset.

## Structure
- `regbank_pkg`:
  - `state_t` (IDLE, WACK, RACK).
  - `word_idx` function for address decode.
  - Mask-overlap check function.
- Sub-module `regbank_word`: one per register, generated `N_REGS` times. Holds the RW/sticky flops and the pulse/clear logic, and takes per-word slices of the masks.
- The top level holds the FSM, decode, read mux and irq reduction.

## Test plan
- Config `N_REGS`=4, `DATA_W`=32, word 0 `RW_MASK`=0x0000FFFF, `RST_VAL`=0x1234: after reset, read 0x0 → 0x00001234; `hw_out[15:0]`=0x1234.
- Write 0x0 data 0xAAAA5555 with strb=0b0001 → read returns 0x00001255; `mem_w_ack` occurs exactly 1 cycle after req.
- Word 1 `W1C_MASK`=0xFF, `IRQ_MASK`=0x01: pulse `hw_in[32]` for 1 cycle → `irq`=1 two cycles later. Write 0x4 data 0x1 → `hw_clr[32]`=1 for 1 cycle and `irq` drops. Hold `hw_in[32]`=1 during the write → the bit stays 1.
- Word 2 `RC_MASK`=0xF0: set bits via `hw_in` → the first read returns 0xF0, the second returns 0x00.
- Word 3 `PULSE_MASK`=0x1: write 0xC data 0x1 → `hw_pulse[96]` high for exactly 1 cycle; read 0xC → 0.
- Simultaneous `mem_w_req` and `mem_r_req` → write acked first, read acked 2 cycles later. Access to 0x10 → acked, `decode_err`=1, read data 0. Assert `rst` during WACK → no ack and all outputs return to reset values.
